// File: rtl/tx_arbiter.sv
// Two-source arbiter in front of a single UART transmitter: grants one byte per frame,
// follows the transmitter's ready handshake, then holds off for a guard gap.
module tx_arbiter #(
    parameter int GUARD_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic [7:0] byte_a,
    input  logic       req_b,
    input  logic [7:0] byte_b,
    input  logic       transmit_ready,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       tx_ctrl,
    output logic [7:0] tx_byte,
    output logic       busy,
    output logic       last_src,
    output logic [7:0] frames_sent,
    output logic       timeout_err,
    output logic [2:0] fsm_state
);

    // Handshake: a source holds req and its byte until it sees its one-cycle gnt,
    // then drops req; tx_ctrl pulses once per frame and tx_byte stays valid after it.

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        GUARD     = 3'd4
    } state_t;

    localparam logic [7:0]  GUARD_LAST = 8'(GUARD_CYCLES - 1);
    localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      next_state;
    logic        ptr;
    logic [15:0] to_cnt;
    logic [7:0]  guard_cnt;

    logic        win_b;
    logic        to_expired;

    logic        gnt_a_d;
    logic        gnt_b_d;
    logic        tx_ctrl_d;
    logic [7:0]  tx_byte_d;
    logic        busy_d;
    logic        last_src_d;
    logic [7:0]  frames_d;
    logic        err_d;
    logic        ptr_d;
    logic [15:0] to_cnt_d;
    logic [7:0]  guard_cnt_d;

    // ptr = 1 means B holds priority when both sources request together
    assign win_b      = req_b & (~req_a | ptr);
    assign to_expired = (to_cnt == TO_LAST);
    assign fsm_state  = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            gnt_a       <= 1'b0;
            gnt_b       <= 1'b0;
            tx_ctrl     <= 1'b0;
            tx_byte     <= 8'h00;
            busy        <= 1'b0;
            last_src    <= 1'b0;
            frames_sent <= 8'h00;
            timeout_err <= 1'b0;
            ptr         <= 1'b0;
            to_cnt      <= 16'h0000;
            guard_cnt   <= 8'h00;
        end else begin
            state       <= next_state;
            gnt_a       <= gnt_a_d;
            gnt_b       <= gnt_b_d;
            tx_ctrl     <= tx_ctrl_d;
            tx_byte     <= tx_byte_d;
            busy        <= busy_d;
            last_src    <= last_src_d;
            frames_sent <= frames_d;
            timeout_err <= err_d;
            ptr         <= ptr_d;
            to_cnt      <= to_cnt_d;
            guard_cnt   <= guard_cnt_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if ((req_a | req_b) & transmit_ready) next_state = LAUNCH;
            end
            LAUNCH: next_state = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!transmit_ready)  next_state = WAIT_DONE;
                else if (to_expired)  next_state = IDLE;
            end
            WAIT_DONE: begin
                if (transmit_ready)   next_state = GUARD;
                else if (to_expired)  next_state = IDLE;
            end
            GUARD: begin
                if (guard_cnt == GUARD_LAST) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Next values of the registered outputs; the exit condition beats a same-cycle timeout
    always_comb begin
        gnt_a_d     = 1'b0;
        gnt_b_d     = 1'b0;
        tx_ctrl_d   = 1'b0;
        tx_byte_d   = tx_byte;
        last_src_d  = last_src;
        ptr_d       = ptr;
        frames_d    = frames_sent;
        err_d       = timeout_err;
        busy_d      = (next_state != IDLE);
        to_cnt_d    = 16'h0000;
        guard_cnt_d = 8'h00;

        if (state == IDLE && next_state == LAUNCH) begin
            gnt_a_d    = ~win_b;
            gnt_b_d    = win_b;
            tx_ctrl_d  = 1'b1;
            tx_byte_d  = win_b ? byte_b : byte_a;
            last_src_d = win_b;
            ptr_d      = ~win_b;
        end

        if (state == WAIT_DONE && next_state == GUARD)
            frames_d = frames_sent + 8'd1;

        if ((state == WAIT_BUSY || state == WAIT_DONE) && next_state == IDLE)
            err_d = 1'b1;

        if ((next_state == WAIT_BUSY || next_state == WAIT_DONE) && next_state == state)
            to_cnt_d = to_cnt + 16'd1;

        if (next_state == GUARD && state == GUARD)
            guard_cnt_d = guard_cnt + 8'd1;
    end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: single frame, contention, blocked start,
// wait-phase timeout (second instance, short timeout), frame counter wrap and mid-frame reset.
module tb_tx_arbiter;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LAUNCH    = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_GUARD     = 3'd4;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // default instance
    logic       req_a, req_b, ready;
    logic [7:0] byte_a, byte_b;
    logic       gnt_a, gnt_b, tx_ctrl, busy, last_src, timeout_err;
    logic [7:0] tx_byte, frames_sent;
    logic [2:0] fsm_state;

    // short-timeout instance
    logic       r2_a, r2_b, rdy2;
    logic [7:0] b2_a, b2_b;
    logic       g2_a, g2_b, ctl2, busy2, src2, err2;
    logic [7:0] tbyte2, frames2;
    logic [2:0] st2;

    tx_arbiter dut (
        .clk(clk), .rst(rst), .req_a(req_a), .byte_a(byte_a), .req_b(req_b), .byte_b(byte_b),
        .transmit_ready(ready), .gnt_a(gnt_a), .gnt_b(gnt_b), .tx_ctrl(tx_ctrl), .tx_byte(tx_byte),
        .busy(busy), .last_src(last_src), .frames_sent(frames_sent), .timeout_err(timeout_err),
        .fsm_state(fsm_state)
    );

    tx_arbiter #(.GUARD_CYCLES(16), .TIMEOUT_CYCLES(8)) dut2 (
        .clk(clk), .rst(rst), .req_a(r2_a), .byte_a(b2_a), .req_b(r2_b), .byte_b(b2_b),
        .transmit_ready(rdy2), .gnt_a(g2_a), .gnt_b(g2_b), .tx_ctrl(ctl2), .tx_byte(tbyte2),
        .busy(busy2), .last_src(src2), .frames_sent(frames2), .timeout_err(err2),
        .fsm_state(st2)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    logic dual_gnt   = 1'b0;
    logic stray_ctrl = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one clock and sample 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        if ((gnt_a && gnt_b) || (g2_a && g2_b)) dual_gnt = 1'b1;
        if ((tx_ctrl && fsm_state != S_LAUNCH) || (ctl2 && st2 != S_LAUNCH)) stray_ctrl = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_grant();
        int n = 0;
        while (!(gnt_a || gnt_b) && n < 100) begin
            tick();
            n++;
        end
        check_eq("gnt_seen", {31'd0, gnt_a | gnt_b}, 32'd1);
    endtask

    task automatic check_grant(input logic exp_src, input logic [7:0] exp_byte);
        check_eq("gnt_src_b", {31'd0, gnt_b}, {31'd0, exp_src});
        check_eq("tx_ctrl_launch", {31'd0, tx_ctrl}, 32'd1);
        check_eq("tx_byte", {24'd0, tx_byte}, {24'd0, exp_byte});
        check_eq("last_src", {31'd0, last_src}, {31'd0, exp_src});
    endtask

    // uart model: ready drops drop_dly cycles after tx_ctrl, returns low_len cycles later
    task automatic finish_frame(input int drop_dly, input int low_len);
        repeat (drop_dly) tick();
        ready = 1'b0;
        repeat (low_len) tick();
        ready = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check_eq("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    logic [7:0] exp_frames;
    int         gsum;

    initial begin
        rst = 1'b1;
        req_a = 1'b0; req_b = 1'b0; byte_a = 8'h00; byte_b = 8'h00; ready = 1'b1;
        r2_a = 1'b0; r2_b = 1'b0; b2_a = 8'h00; b2_b = 8'h00; rdy2 = 1'b1;
        tick();
        tick();

        // reset state
        check_eq("rst_state", {29'd0, fsm_state}, {29'd0, S_IDLE});
        check_eq("rst_outputs", {24'd0, gnt_a, gnt_b, tx_ctrl, busy, last_src, timeout_err, 2'b00}, 32'd0);
        check_eq("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
        check_eq("rst_frames", {24'd0, frames_sent}, 32'd0);

        // single request from A
        rst = 1'b0;
        req_a = 1'b1; byte_a = 8'h41;
        tick();
        check_eq("single_gnt_a", {31'd0, gnt_a}, 32'd1);
        check_eq("single_gnt_b", {31'd0, gnt_b}, 32'd0);
        check_grant(1'b0, 8'h41);
        check_eq("single_busy", {31'd0, busy}, 32'd1);
        req_a = 1'b0;
        tick();
        check_eq("single_gnt_pulse", {30'd0, gnt_a, tx_ctrl}, 32'd0);
        check_eq("single_wait_busy", {29'd0, fsm_state}, {29'd0, S_WAIT_BUSY});
        check_eq("single_byte_hold", {24'd0, tx_byte}, 32'h41);
        tick();
        ready = 1'b0;
        repeat (10) tick();
        check_eq("single_wait_done", {29'd0, fsm_state}, {29'd0, S_WAIT_DONE});
        check_eq("single_frames_0", {24'd0, frames_sent}, 32'd0);
        ready = 1'b1;
        tick();
        check_eq("single_guard", {29'd0, fsm_state}, {29'd0, S_GUARD});
        check_eq("single_frames_1", {24'd0, frames_sent}, 32'd1);
        repeat (15) tick();
        check_eq("single_guard_15", {29'd0, fsm_state}, {29'd0, S_GUARD});
        tick();
        check_eq("single_idle_16", {29'd0, fsm_state}, {29'd0, S_IDLE});
        check_eq("single_busy_low", {31'd0, busy}, 32'd0);

        // contention: strict alternation starting with A
        do_reset();
        req_a = 1'b1; req_b = 1'b1; byte_a = 8'h41; byte_b = 8'h42;
        for (int i = 0; i < 4; i++) begin
            wait_grant();
            check_grant(i[0], (i[0] ? 8'h42 : 8'h41));
            finish_frame(2, 3);
            wait_idle();
        end
        req_a = 1'b0; req_b = 1'b0;
        check_eq("no_dual_gnt", {31'd0, dual_gnt}, 32'd0);

        // blocked start: no grant while transmitter is busy
        do_reset();
        ready = 1'b0; req_b = 1'b1; byte_b = 8'h42;
        gsum = 0;
        repeat (50) begin
            tick();
            if (gnt_a || gnt_b || tx_ctrl) gsum++;
        end
        check_eq("blocked_no_gnt", gsum, 32'd0);
        ready = 1'b1;
        tick();
        check_eq("blocked_gnt_b", {31'd0, gnt_b}, 32'd1);
        check_grant(1'b1, 8'h42);
        req_b = 1'b0;
        finish_frame(2, 3);
        wait_idle();

        // timeout on the short-timeout instance
        r2_a = 1'b1; b2_a = 8'h55;
        tick();
        check_eq("to_gnt_a", {30'd0, g2_a, ctl2}, 32'd3);
        check_eq("to_byte", {24'd0, tbyte2}, 32'h55);
        r2_a = 1'b0;
        tick();
        check_eq("to_wait_busy", {29'd0, st2}, {29'd0, S_WAIT_BUSY});
        repeat (7) tick();
        check_eq("to_still_busy", {29'd0, st2}, {29'd0, S_WAIT_BUSY});
        check_eq("to_err_early", {31'd0, err2}, 32'd0);
        tick();
        check_eq("to_err_set", {31'd0, err2}, 32'd1);
        check_eq("to_idle", {29'd0, st2}, {29'd0, S_IDLE});
        check_eq("to_frames", {24'd0, frames2}, 32'd0);
        check_eq("to_busy_low", {31'd0, busy2}, 32'd0);
        r2_b = 1'b1; b2_b = 8'h66;
        tick();
        check_eq("to_next_gnt_b", {31'd0, g2_b}, 32'd1);
        check_eq("to_next_byte", {24'd0, tbyte2}, 32'h66);
        check_eq("to_err_sticky", {31'd0, err2}, 32'd1);
        r2_b = 1'b0;

        // frame counter wrap
        do_reset();
        req_a = 1'b1; req_b = 1'b1; byte_a = 8'h41; byte_b = 8'h42;
        exp_frames = 8'h00;
        for (int k = 0; k < 256; k++) begin
            wait_grant();
            finish_frame(1, 1);
            wait_idle();
            exp_frames = exp_frames + 8'd1;
            check_eq("wrap_frames", {24'd0, frames_sent}, {24'd0, exp_frames});
        end
        check_eq("wrap_zero", {24'd0, frames_sent}, 32'd0);

        // reset during WAIT_DONE
        wait_grant();
        check_grant(1'b0, 8'h41);
        tick();
        ready = 1'b0;
        tick();
        tick();
        check_eq("mid_wait_done", {29'd0, fsm_state}, {29'd0, S_WAIT_DONE});
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
        tick();
        check_eq("mid_rst_state", {29'd0, fsm_state}, {29'd0, S_IDLE});
        check_eq("mid_rst_outputs", {24'd0, gnt_a, gnt_b, tx_ctrl, busy, last_src, timeout_err, 2'b00}, 32'd0);
        check_eq("mid_rst_tx_byte", {24'd0, tx_byte}, 32'd0);
        check_eq("mid_rst_frames", {24'd0, frames_sent}, 32'd0);
        rst = 1'b0;
        ready = 1'b1;
        repeat (5) tick();
        check_eq("mid_rise_ignored", {24'd0, frames_sent}, 32'd0);
        check_eq("mid_still_idle", {29'd0, fsm_state}, {29'd0, S_IDLE});
        req_a = 1'b1; req_b = 1'b1;
        wait_grant();
        check_eq("mid_ptr_reset_a", {30'd0, gnt_a, gnt_b}, 32'd2);
        req_a = 1'b0; req_b = 1'b0;
        tick();

        check_eq("no_dual_gnt_final", {31'd0, dual_gnt}, 32'd0);
        check_eq("no_stray_tx_ctrl", {31'd0, stray_ctrl}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter GUARD_CYCLES, default 16, idle gap in clk cycles after each frame before the next grant; legal range 1..255.
REQ-002 Parameter TIMEOUT_CYCLES, default 20000, max clk cycles allowed in each UART wait phase; legal range 2..65535.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_a  input  1  player requester (msg_reg side) wants to send byte_a.
REQ-006 byte_a  input  8  player byte; held stable while req_a high.
REQ-007 req_b  input  1  host requester (status/ack path) wants to send byte_b.
REQ-008 byte_b  input  8  host byte; held stable while req_b high.
REQ-009 gnt_a / gnt_b  output  1 each  one-cycle grant pulse; byte accepted.
REQ-010 transmit_ready  input  1  from uart_tx; high = transmitter idle.
REQ-011 tx_ctrl  output  1  one-cycle start pulse to uart_tx.
REQ-012 tx_byte  output  8  byte to uart_tx; stable from tx_ctrl until the next grant.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 last_src  output  1  source of the most recent grant (0 = A, 1 = B).
REQ-015 frames_sent  output  8  count of completed frames; wraps 255 -> 0.
REQ-016 timeout_err  output  1  sticky; set on any wait-phase timeout.

Function
REQ-017 States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GUARD; all outputs registered.
REQ-018 IDLE -> LAUNCH at an edge where (req_a or req_b) and transmit_ready are high; no grant while transmit_ready is low.
REQ-019 Winner selection: a single requester wins outright; if both request, the holder of the priority pointer wins; the pointer resets to A.
REQ-020 After each grant, the pointer moves to the non-granted source, giving strict alternation under continuous contention.
REQ-021 In the cycle after the IDLE -> LAUNCH edge (the LAUNCH cycle), the winner's gnt and tx_ctrl are high for exactly one cycle, tx_byte holds the winner's byte, and last_src is updated.
REQ-022 Latency: request seen at edge N -> gnt/tx_ctrl high in cycle N+1.
REQ-023 LAUNCH -> WAIT_BUSY unconditionally after one cycle.
REQ-024 WAIT_BUSY -> WAIT_DONE when transmit_ready is low.
REQ-025 WAIT_DONE -> GUARD when transmit_ready returns high; frames_sent increments on this transition.
REQ-026 GUARD counts GUARD_CYCLES cycles, then -> IDLE; requests are ignored during GUARD.
REQ-027 Requesters drop req in the cycle after gnt; the GUARD_CYCLES >= 1 minimum prevents a double grant.
REQ-028 Timeout counter clears on entry to WAIT_BUSY and to WAIT_DONE and increments each cycle in those states.
REQ-029 When the timeout counter reaches TIMEOUT_CYCLES-1 without the exit condition: set timeout_err, go to IDLE, do not increment frames_sent, do not move the pointer back.
REQ-030 A request withdrawn before grant is dropped silently; no grant is owed.
REQ-031 gnt_a and gnt_b are never high in the same cycle; tx_ctrl is never high outside LAUNCH.

Reset
REQ-032 rst high at an edge forces IDLE, gnt_a = gnt_b = tx_ctrl = 0, tx_byte = 8'h00, busy = 0, last_src = 0, frames_sent = 0, timeout_err = 0, pointer = A, all counters 0.
REQ-033 rst asserted mid-frame (any state) aborts the frame with no tx_ctrl pulse; a later transmit_ready rise does not increment frames_sent.

Verification
REQ-034 Single request: req_a = 1, byte_a = 8'h41, transmit_ready high; uart model drops ready 2 cycles after tx_ctrl and raises it 10 cycles later -> gnt_a and tx_ctrl one cycle in cycle N+1, tx_byte = 8'h41, frames_sent = 1, IDLE after 16 GUARD cycles.
REQ-035 Contention: req_a and req_b held high continuously with bytes 8'h41 and 8'h42 -> grant order A, B, A, B; tx_byte sequence 41, 42, 41, 42; never two gnts in one cycle.
REQ-036 Blocked start: req_b high while transmit_ready low for 50 cycles -> no grant until transmit_ready rises, then gnt_b in the next cycle.
REQ-037 Timeout: TIMEOUT_CYCLES = 8, transmit_ready stuck high after tx_ctrl -> timeout_err = 1 after 8 cycles in WAIT_BUSY, state IDLE, frames_sent unchanged, next request still granted.
REQ-038 Wrap and reset: complete 256 frames -> frames_sent = 0; assert rst during WAIT_DONE -> all REQ-032 values next cycle, and the later ready rise is not counted.
